// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the two-read, one-write register file.
// The strobe merge is written at a fixed maximum width so one function serves every instance.
package reg_file_pkg;

   typedef enum logic {
      StIdle,
      StClear
   } rfStateT;

   localparam int unsigned MAX_MEM_WIDTH  = 256;
   localparam int unsigned MAX_STRB_WIDTH = MAX_MEM_WIDTH / 8;

   function automatic int unsigned strbWidth(input int unsigned memWidth);
      return memWidth / 8;
   endfunction

   // Callers zero-extend into the maximum width and cast the result back down.
   function automatic logic [MAX_MEM_WIDTH-1:0] strbMerge(
      input logic [MAX_MEM_WIDTH-1:0]  oldWord,
      input logic [MAX_MEM_WIDTH-1:0]  newWord,
      input logic [MAX_STRB_WIDTH-1:0] strb
   );
      logic [MAX_MEM_WIDTH-1:0] merged;
      merged = oldWord;
      for (int unsigned i = 0; i < MAX_STRB_WIDTH; i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = newWord[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, storage select, same-cycle write bypass
// and the RdData/RdValid/RdErr output registers.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned MEM_WIDTH  = 16,
   parameter int unsigned MEM_DEPTH  = 8
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              rdEn,
   input  logic [ADDR_WIDTH-1:0]             rdAddr,
   input  logic [MEM_DEPTH*MEM_WIDTH-1:0]    mem,
   input  logic                              wrEn,
   input  logic [ADDR_WIDTH-1:0]             wrAddr,
   input  logic [MEM_WIDTH-1:0]              wrData,
   input  logic [strbWidth(MEM_WIDTH)-1:0]   wrStrb,
   output logic [MEM_WIDTH-1:0]              rdData,
   output logic                              rdValid,
   output logic                              rdErr
);

   localparam int unsigned IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic                 inRange;
   logic                 bypass;
   logic [IDX_WIDTH-1:0] idx;
   logic [MEM_WIDTH-1:0] stored;
   logic [MEM_WIDTH-1:0] merged;
   logic [MEM_WIDTH-1:0] word;

   assign inRange = (32'(rdAddr) < MEM_DEPTH);
   assign idx     = rdAddr[IDX_WIDTH-1:0];
   assign stored  = mem[32'(idx)*MEM_WIDTH +: MEM_WIDTH];

   // wrEn is already qualified with range and FSM state by the top level.
   assign bypass  = wrEn & (wrAddr == rdAddr);
   assign merged  = MEM_WIDTH'(strbMerge(MAX_MEM_WIDTH'(stored), MAX_MEM_WIDTH'(wrData),
                                         MAX_STRB_WIDTH'(wrStrb)));
   assign word    = bypass ? merged : stored;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdData  <= '0;
         rdValid <= 1'b0;
         rdErr   <= 1'b0;
      end else begin
         rdValid <= rdEn;
         rdErr   <= rdEn & ~inRange;
         if (rdEn) begin
            rdData <= inRange ? word : '0;
         end
      end
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// General-purpose operand store: storage array, byte-strobed write port, clear sweep FSM
// and two independent registered read ports with write bypass.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned MEM_WIDTH  = 16,
   parameter int unsigned MEM_DEPTH  = 8
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            WrEn,
   input  logic [ADDR_WIDTH-1:0]           WrAddr,
   input  logic [MEM_WIDTH-1:0]            WrData,
   input  logic [strbWidth(MEM_WIDTH)-1:0] WrStrb,
   input  logic                            RdEnA,
   input  logic [ADDR_WIDTH-1:0]           RdAddrA,
   output logic [MEM_WIDTH-1:0]            RdDataA,
   output logic                            RdValidA,
   output logic                            RdErrA,
   input  logic                            RdEnB,
   input  logic [ADDR_WIDTH-1:0]           RdAddrB,
   output logic [MEM_WIDTH-1:0]            RdDataB,
   output logic                            RdValidB,
   output logic                            RdErrB,
   input  logic                            Clr,
   output logic                            Busy
);

   localparam int unsigned IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   if (MEM_WIDTH % 8 != 0 || MEM_WIDTH > MAX_MEM_WIDTH) begin : gBadWidth
      $error("reg_file_2r1w: MEM_WIDTH must be a multiple of 8 and at most MAX_MEM_WIDTH");
   end
   if (MEM_DEPTH > (1 << ADDR_WIDTH)) begin : gBadDepth
      $error("reg_file_2r1w: MEM_DEPTH exceeds the address space");
   end

   rfStateT                        stateQ, stateD;
   logic [IDX_WIDTH-1:0]           ptrQ, ptrD;
   logic [MEM_WIDTH-1:0]           memQ [MEM_DEPTH];
   logic [MEM_DEPTH*MEM_WIDTH-1:0] memFlat;

   logic                 idle;
   logic                 wrInRange;
   logic                 wrAccept;
   logic [IDX_WIDTH-1:0] wrIdx;
   logic [MEM_WIDTH-1:0] wrMerged;
   logic                 rdReqA;
   logic                 rdReqB;

   assign idle      = (stateQ == StIdle);
   assign wrInRange = (32'(WrAddr) < MEM_DEPTH);
   // A clear request in the same cycle takes priority and drops the write.
   assign wrAccept  = idle & WrEn & ~Clr & wrInRange;
   assign wrIdx     = WrAddr[IDX_WIDTH-1:0];
   assign wrMerged  = MEM_WIDTH'(strbMerge(MAX_MEM_WIDTH'(memQ[wrIdx]), MAX_MEM_WIDTH'(WrData),
                                           MAX_STRB_WIDTH'(WrStrb)));

   assign rdReqA = RdEnA & idle;
   assign rdReqB = RdEnB & idle;
   assign Busy   = (stateQ == StClear);

   for (genvar g = 0; g < MEM_DEPTH; g++) begin : gFlat
      assign memFlat[g*MEM_WIDTH +: MEM_WIDTH] = memQ[g];
   end

   always_comb begin
      stateD = stateQ;
      ptrD   = ptrQ;
      case (stateQ)
         StIdle: begin
            if (Clr) begin
               stateD = StClear;
               ptrD   = '0;
            end
         end
         StClear: begin
            if (ptrQ == IDX_WIDTH'(MEM_DEPTH - 1)) begin
               stateD = StIdle;
               ptrD   = '0;
            end else begin
               ptrD = ptrQ + IDX_WIDTH'(1);
            end
         end
         default: begin
            stateD = StIdle;
            ptrD   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stateQ <= StIdle;
         ptrQ   <= '0;
      end else begin
         stateQ <= stateD;
         ptrQ   <= ptrD;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            memQ[i] <= '0;
         end
      end else if (stateQ == StClear) begin
         memQ[ptrQ] <= '0;
      end else if (wrAccept) begin
         memQ[wrIdx] <= wrMerged;
      end
   end

   reg_file_rd_port #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .MEM_WIDTH (MEM_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) uRdPortA (
      .CLK    (CLK),
      .RST    (RST),
      .rdEn   (rdReqA),
      .rdAddr (RdAddrA),
      .mem    (memFlat),
      .wrEn   (wrAccept),
      .wrAddr (WrAddr),
      .wrData (WrData),
      .wrStrb (WrStrb),
      .rdData (RdDataA),
      .rdValid(RdValidA),
      .rdErr  (RdErrA)
   );

   reg_file_rd_port #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .MEM_WIDTH (MEM_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) uRdPortB (
      .CLK    (CLK),
      .RST    (RST),
      .rdEn   (rdReqB),
      .rdAddr (RdAddrB),
      .mem    (memFlat),
      .wrEn   (wrAccept),
      .wrAddr (WrAddr),
      .wrData (WrData),
      .wrStrb (WrStrb),
      .rdData (RdDataB),
      .rdValid(RdValidB),
      .rdErr  (RdErrB)
   );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomised and directed bench for reg_file_2r1w against a behavioural model of
// the register file (array of words, sweep countdown, held read outputs).
module tb_reg_file_2r1w;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WrEn;
   logic [3:0]  WrAddr;
   logic [15:0] WrData;
   logic [1:0]  WrStrb;
   logic        RdEnA, RdEnB;
   logic [3:0]  RdAddrA, RdAddrB;
   logic [15:0] RdDataA, RdDataB;
   logic        RdValidA, RdValidB, RdErrA, RdErrB;
   logic        Clr;
   logic        Busy;

   reg_file_2r1w #(
      .ADDR_WIDTH(4),
      .MEM_WIDTH (16),
      .MEM_DEPTH (8)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .WrEn    (WrEn),
      .WrAddr  (WrAddr),
      .WrData  (WrData),
      .WrStrb  (WrStrb),
      .RdEnA   (RdEnA),
      .RdAddrA (RdAddrA),
      .RdDataA (RdDataA),
      .RdValidA(RdValidA),
      .RdErrA  (RdErrA),
      .RdEnB   (RdEnB),
      .RdAddrB (RdAddrB),
      .RdDataB (RdDataB),
      .RdValidB(RdValidB),
      .RdErrB  (RdErrB),
      .Clr     (Clr),
      .Busy    (Busy)
   );

   always #5 CLK = ~CLK;

   int    total = 0;
   int    bad   = 0;
   string curTest = "init";

   logic [15:0] mdl [8];
   int          sweepLeft = 0;
   logic [15:0] expDA = '0, expDB = '0;
   logic        expVA = 0, expVB = 0, expEA = 0, expEB = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s/%s: got %0h want %0h", curTest, tag, got, want);
      end
   endtask

   function automatic logic [15:0] mergeRef(input logic [15:0] oldW, input logic [15:0] newW,
                                            input logic [1:0] s);
      logic [15:0] m;
      m = {{8{s[1]}}, {8{s[0]}}};
      return (oldW & ~m) | (newW & m);
   endfunction

   function automatic logic [15:0] readWord(input int addr, input bit wacc, input int wa,
                                            input logic [15:0] post);
      return (wacc && wa == addr) ? post : mdl[addr];
   endfunction

   task automatic checkOutputs(input string tag);
      checkVal({tag, ".validA"}, 32'(RdValidA), 32'(expVA));
      checkVal({tag, ".errA"},   32'(RdErrA),   32'(expEA));
      checkVal({tag, ".dataA"},  32'(RdDataA),  32'(expDA));
      checkVal({tag, ".validB"}, 32'(RdValidB), 32'(expVB));
      checkVal({tag, ".errB"},   32'(RdErrB),   32'(expEB));
      checkVal({tag, ".dataB"},  32'(RdDataB),  32'(expDB));
      checkVal({tag, ".busy"},   32'(Busy),     32'(sweepLeft > 0));
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, check after the edge.
   task automatic step(input bit wen, input int wa, input int wd, input int ws,
                       input bit ea, input int aa, input bit eb, input int ab, input bit clr);
      bit          wacc;
      logic [15:0] post;
      @(negedge CLK);
      WrEn = wen;  WrAddr = 4'(wa); WrData = 16'(wd); WrStrb = 2'(ws);
      RdEnA = ea;  RdAddrA = 4'(aa); RdEnB = eb; RdAddrB = 4'(ab); Clr = clr;
      if (sweepLeft > 0) begin
         mdl[8 - sweepLeft] = '0;
         sweepLeft--;
         expVA = 0; expEA = 0; expVB = 0; expEB = 0;
      end else begin
         wacc = wen && !clr && wa < 8;
         post = wacc ? mergeRef(mdl[wa], 16'(wd), 2'(ws)) : '0;
         expVA = ea; expEA = ea && aa >= 8;
         if (ea) expDA = (aa >= 8) ? 16'h0 : readWord(aa, wacc, wa, post);
         expVB = eb; expEB = eb && ab >= 8;
         if (eb) expDB = (ab >= 8) ? 16'h0 : readWord(ab, wacc, wa, post);
         if (wacc) mdl[wa] = post;
         if (clr) sweepLeft = 8;
      end
      @(posedge CLK);
      #1;
      checkOutputs("step");
   endtask

   task automatic applyReset();
      RST = 1'b0;
      WrEn = 0; RdEnA = 0; RdEnB = 0; Clr = 0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      sweepLeft = 0;
      expDA = '0; expDB = '0; expVA = 0; expVB = 0; expEA = 0; expEB = 0;
      #1;
      checkOutputs("rst");
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      RST = 1'b0;
      WrEn = 0; WrAddr = '0; WrData = '0; WrStrb = '0;
      RdEnA = 0; RdAddrA = '0; RdEnB = 0; RdAddrB = '0; Clr = 0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      @(posedge CLK);
      #1;
      curTest = "reset";
      checkOutputs("rst");
      @(negedge CLK);
      RST = 1'b1;

      curTest = "basic";
      step(1, 2, 13, 3, 0, 0, 0, 0, 0);
      step(1, 6, 8, 3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 2, 1, 6, 0);
      checkVal("dataA", 32'(RdDataA), 32'd13);
      checkVal("dataB", 32'(RdDataB), 32'd8);
      checkVal("valid", 32'({RdValidA, RdValidB, RdErrA, RdErrB}), 32'b1100);

      curTest = "strobe";
      step(1, 3, 16'hABCD, 3, 0, 0, 0, 0, 0);
      step(1, 3, 16'h1234, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 3, 0, 0, 0);
      checkVal("dataA", 32'(RdDataA), 32'hAB34);

      curTest = "bypass";
      step(1, 5, 16'h00FF, 3, 0, 0, 0, 0, 0);
      step(1, 5, 16'h5500, 2, 1, 5, 1, 5, 0);
      checkVal("dataA", 32'(RdDataA), 32'h55FF);
      checkVal("dataB", 32'(RdDataB), 32'h55FF);

      curTest = "oob";
      step(1, 9, 16'hFFFF, 3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 9, 0, 0, 0);
      checkVal("dataA", 32'(RdDataA), 32'h0);
      checkVal("flags", 32'({RdValidA, RdErrA}), 32'b11);
      for (int a = 0; a < 8; a++) step(0, 0, 0, 0, 1, a, 1, 7 - a, 0);

      curTest = "clear";
      for (int a = 0; a < 8; a++) step(1, a, 16'($urandom) | 16'h0101, 3, 0, 0, 0, 0, 0);
      step(1, 1, 16'hBEEF, 3, 1, 1, 1, 4, 1);
      bc = int'(Busy);
      for (int i = 0; i < 10; i++) begin
         step(i < 8, 1, 16'hBEEF, 3, i < 8, i, i < 8, 1, 0);
         bc += int'(Busy);
      end
      checkVal("busyLen", 32'(bc), 32'd8);
      for (int a = 0; a < 8; a++) begin
         step(0, 0, 0, 0, 1, a, 0, 0, 0);
         checkVal("zeroA", 32'(RdDataA), 32'h0);
      end

      curTest = "rstSweep";
      for (int a = 0; a < 8; a++) step(1, a, 16'hC000 + a, 3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      applyReset();
      step(0, 0, 0, 0, 0, 0, 1, 7, 0);
      checkVal("dataB7", 32'(RdDataB), 32'h0);
      checkVal("idle", 32'({Busy, RdValidB}), 32'b01);
      step(1, 7, 16'h1234, 3, 1, 7, 0, 0, 0);
      checkVal("idleWr", 32'(RdDataA), 32'h1234);

      curTest = "random";
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 39) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised successor to the single-port 8x16 register file: one write port with byte strobes and two independent registered read ports. Adds write-to-read bypass, out-of-range detection, and a sequenced clear engine. Sits beside the datapath as the general-purpose operand store; both read ports can feed a two-operand unit every cycle.

## Interface
- ADDR_WIDTH, 4: address width for all ports.
- MEM_WIDTH, 16: word width; must be a multiple of 8.
- MEM_DEPTH, 8: number of entries; must be ≤ 2**ADDR_WIDTH.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-low.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_WIDTH  write address.
- WrData  in  MEM_WIDTH  write data.
- WrStrb  in  MEM_WIDTH/8  byte enables; bit i covers WrData[8i+7:8i].
- RdEnA / RdEnB  in  1  read request, port A / B.
- RdAddrA / RdAddrB  in  ADDR_WIDTH  read address.
- RdDataA / RdDataB  out  MEM_WIDTH  registered read data.
- RdValidA / RdValidB  out  1  one-cycle strobe, RdData valid.
- RdErrA / RdErrB  out  1  qualifies RdValid: address ≥ MEM_DEPTH.
- Clr  in  1  start clear sweep (pulse).
- Busy  out  1  clear sweep in progress.

## Operation
- Reset (RST low): all entries 0, RdDataA/B 0, RdValidA/B 0, RdErrA/B 0, Busy 0, FSM IDLE, sweep pointer 0. Takes effect immediately, mid-sweep or mid-read; pending reads dropped.
- Write (IDLE, WrEn=1, WrAddr < MEM_DEPTH): bytes with WrStrb=1 updated, others kept. WrStrb=0 is a legal no-op. WrAddr ≥ MEM_DEPTH: write dropped, no flag.
- Read (IDLE, RdEnX=1): RdAddrX < MEM_DEPTH → RdDataX = entry, RdErrX=0; otherwise RdDataX = 0, RdErrX=1. RdValidX pulses in both cases.
- Bypass: read and write to same in-range address in same cycle → read returns post-write word (strobed bytes from WrData, others from stored entry). Both ports bypass independently; A and B may use the same address.
- RdDataX holds its last value when no read completes; RdErrX clears with RdValidX.
- FSM states IDLE, CLEAR.
  - IDLE → CLEAR on Clr=1. Clr beats WrEn that cycle (write dropped); reads in that cycle are served with pre-clear data.
  - CLEAR: one entry zeroed per cycle, pointer 0..MEM_DEPTH-1; after zeroing entry MEM_DEPTH-1 → IDLE, pointer back to 0.
  - In CLEAR, WrEn, RdEnA/B, and Clr are ignored: no write, no RdValid.
- Busy = (state == CLEAR), registered.

## Timing
- Write latency 1: data written on edge N visible to a read issued on cycle N+1, and via bypass to a read issued on cycle N.
- Read latency 1: request sampled on edge N → RdDataX/RdValidX/RdErrX valid after edge N, for one cycle.
- Back-to-back reads on every cycle are supported on both ports: full throughput.
- Clr sampled on edge N → Busy high from edge N through edge N+MEM_DEPTH, low after edge N+MEM_DEPTH; first accepted access is on cycle N+MEM_DEPTH+1. Sweep takes exactly MEM_DEPTH cycles.
- No combinational path from inputs to outputs.

## Structure
- Package reg_file_pkg: state enum (IDLE, CLEAR), STRB_WIDTH = MEM_WIDTH/8 helper, strobe-merge function (old word, new word, strobe → merged word), shared by the write path and both bypass paths.
- Sub-module reg_file_rd_port, instantiated twice: address range check, storage mux, bypass compare/merge, and output registers for RdData/RdValid/RdErr.
- Top level: storage array, write logic, clear FSM and pointer.

## Test plan
- Reset then basic access: write 13 → addr 2 and 8 → addr 6 with WrStrb=2'b11; read A@2, B@6 same cycle → next cycle RdDataA=13, RdDataB=8, both RdValid=1, RdErr=0.
- Byte strobe: addr 3 = 16'hABCD; write 16'h1234 with WrStrb=2'b01 → read returns 16'hAB34.
- Bypass: addr 5 = 16'h00FF; same cycle write 16'h5500 WrStrb=2'b10 and read A@5, B@5 → both return 16'h55FF.
- Out of range: MEM_DEPTH=8, write 16'hFFFF → addr 9, read A@9 → RdDataA=0, RdValidA=1, RdErrA=1; entry contents unchanged.
- Clear sweep: fill all 8 entries nonzero, pulse Clr with WrEn to addr 1 → Busy high exactly 8 cycles, reads during Busy give no RdValid; after Busy falls every entry reads 0, write to addr 1 not applied.
- Reset mid-sweep: drop RST on cycle 3 of CLEAR → Busy=0, all outputs 0 immediately; after release, read addr 7 → 0 and FSM in IDLE.
